// File: rtl/frac_loop_divider_pkg.sv
// Shared definitions for the fractional-N loop divider.
//   state_t  : divider FSM encoding (IDLE, RUN)
//   N_MIN    : smallest legal integer ratio; smaller requests are raised to it
//   clamp_n  : applies N_MIN to a requested integer ratio
package loop_div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned N_MIN = 32'd2;

    // Ratios 0 and 1 cannot produce a high and a low phase, so they become N_MIN.
    function automatic logic [31:0] clamp_n(input logic [31:0] n);
        logic [31:0] r;
        if (n < N_MIN) begin
            r = N_MIN;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/frac_loop_divider_if.sv
// Ratio configuration channel of the fractional-N loop divider.
//   cfg_valid : new ratio offered (source holds values until accepted)
//   cfg_ready : divider shadow register is free
//   cfg_n     : integer ratio (W bits, 0/1 clamp to 2)
//   cfg_frac  : fractional part, value = cfg_frac / 2^F
//   cfg_fen   : fractional mode enable
// master = configuration source, slave = divider.
interface frac_loop_divider_if #(
    parameter int W = 6,
    parameter int F = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_n;
    logic [F-1:0] cfg_frac;
    logic         cfg_fen;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_frac,
        output cfg_fen,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_frac,
        input  cfg_fen,
        output cfg_ready
    );
endinterface

// File: rtl/frac_loop_divider_frac.sv
// First-order fractional accumulator (dual-modulus N/N+1 control).
//   clk, rstn : divider clock, async active-low reset
//   frac      : fraction to add at each period start
//   fen       : fractional mode enable; when low no carry is produced
//   load      : period start; accumulator takes acc + frac when fen is set
//   clear     : new config applied; accumulator restarts from zero
//   carry     : carry out of the addition for the period being started
module frac_acc #(
    parameter int F = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [F-1:0] frac,
    input  logic         fen,
    input  logic         load,
    input  logic         clear,
    output logic         carry
);

    logic [F-1:0] acc_r;
    logic [F-1:0] base_s;
    logic [F:0]   sum_s;

    // Sum seen by the period being started; a clear restarts from zero in the same cycle.
    always_comb begin
        if (clear) begin
            base_s = {F{1'b0}};
        end else begin
            base_s = acc_r;
        end
        sum_s = {1'b0, base_s} + {1'b0, frac};
        carry = fen & sum_s[F];
    end

    // Accumulator register, wraps modulo 2^F.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r <= {F{1'b0}};
        end else if (load && fen) begin
            acc_r <= sum_s[F-1:0];
        end else if (clear) begin
            acc_r <= {F{1'b0}};
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/frac_loop_divider.sv
// Programmable fractional-N PLL loop divider.
//   clk   : divider input clock (all logic on rising edge)
//   rstn  : asynchronous active-low reset
//   en    : run request; dropping it lets the current period finish
//   cfg   : ratio configuration channel (valid/ready, shadowed)
//   clko  : divided clock, high for floor(p/2) of each p-cycle period
//   clkob : registered inverse of clko
//   tick  : one-cycle pulse on the last clk cycle of each period
// Ratio changes only take effect at period boundaries, so clko never glitches.
module frac_loop_divider
    import loop_div_pkg::*;
#(
    parameter int W     = 6,
    parameter int F     = 8,
    parameter int N_RST = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    frac_loop_divider_if.slave   cfg,
    output logic                 clko,
    output logic                 clkob,
    output logic                 tick
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]   state_r, state_nxt_s;
    logic [W:0]   cnt_r, cnt_nxt_s;
    logic [W:0]   p_r, p_nxt_s, p_start_s;
    logic [W-1:0] n_act_r, sh_n_r, n_eff_s;
    logic [F-1:0] frac_act_r, sh_frac_r, frac_eff_s;
    logic         fen_act_r, sh_fen_r, fen_eff_s;
    logic         pend_r, pend_nxt_s;
    logic         clko_r, clkob_r, tick_r, ready_r;
    logic         run_last_s, start_s, apply_s, accept_s, carry_s;
    logic         clko_nxt_s, tick_nxt_s;

    // Period boundaries, handshake and the config that a starting period will use.
    always_comb begin
        run_last_s = (state_r == ST_RUN) && (cnt_r == (p_r - (W+1)'(1)));
        start_s    = en && ((state_r == ST_IDLE) || run_last_s);
        // A pending config lands at the next period start, or at once while idle.
        apply_s    = pend_r && (start_s || (state_r == ST_IDLE));
        accept_s   = cfg.cfg_valid && !pend_r;
        if (pend_r) begin
            n_eff_s    = sh_n_r;
            frac_eff_s = sh_frac_r;
            fen_eff_s  = sh_fen_r;
        end else begin
            n_eff_s    = n_act_r;
            frac_eff_s = frac_act_r;
            fen_eff_s  = fen_act_r;
        end
        p_start_s = {1'b0, n_eff_s} + {{W{1'b0}}, carry_s};
    end

    // Next-state for FSM, counter, period length and pending flag.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_last_s && !en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        if (start_s) begin
            cnt_nxt_s = {(W+1){1'b0}};
        end else if ((state_r == ST_RUN) && !run_last_s) begin
            cnt_nxt_s = cnt_r + (W+1)'(1);
        end else begin
            cnt_nxt_s = {(W+1){1'b0}};
        end

        if (start_s) begin
            p_nxt_s = p_start_s;
        end else begin
            p_nxt_s = p_r;
        end

        if (accept_s) begin
            pend_nxt_s = 1'b1;
        end else if (apply_s) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // Outputs are decoded from next-state values so they leave flops aligned with cnt.
    always_comb begin
        clko_nxt_s = (state_nxt_s == ST_RUN) && (cnt_nxt_s < (p_nxt_s >> 1));
        tick_nxt_s = (state_nxt_s == ST_RUN) && (cnt_nxt_s == (p_nxt_s - (W+1)'(1)));
    end

    frac_acc #(.F(F)) u_frac_acc (
        .clk   (clk),
        .rstn  (rstn),
        .frac  (frac_eff_s),
        .fen   (fen_eff_s),
        .load  (start_s),
        .clear (apply_s),
        .carry (carry_s)
    );

    // Divider state, shadow/active config and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {(W+1){1'b0}};
            p_r        <= (W+1)'(N_RST);
            n_act_r    <= W'(N_RST);
            frac_act_r <= {F{1'b0}};
            fen_act_r  <= 1'b0;
            sh_n_r     <= W'(N_RST);
            sh_frac_r  <= {F{1'b0}};
            sh_fen_r   <= 1'b0;
            pend_r     <= 1'b0;
            ready_r    <= 1'b1;
            clko_r     <= 1'b0;
            clkob_r    <= 1'b1;
            tick_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            p_r     <= p_nxt_s;
            if (accept_s) begin
                sh_n_r    <= W'(clamp_n(32'(cfg.cfg_n)));
                sh_frac_r <= cfg.cfg_frac;
                sh_fen_r  <= cfg.cfg_fen;
            end
            if (apply_s) begin
                n_act_r    <= sh_n_r;
                frac_act_r <= sh_frac_r;
                fen_act_r  <= sh_fen_r;
            end
            pend_r  <= pend_nxt_s;
            ready_r <= !pend_nxt_s;
            clko_r  <= clko_nxt_s;
            clkob_r <= !clko_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign cfg.cfg_ready = ready_r;
    assign clko          = clko_r;
    assign clkob         = clkob_r;
    assign tick          = tick_r;

endmodule

// File: tb/tb_frac_loop_divider.sv
// Scoreboard bench for frac_loop_divider: expected period lengths are queued
// as each ratio is programmed; a monitor measures every period ending in tick
// and compares its length and high time against the queue head.
module tb_frac_loop_divider;

    localparam int W = 6;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic clko, clkob, tick;

    frac_loop_divider_if #(.W(W), .F(F)) cfg_if ();

    frac_loop_divider #(.W(W), .F(F), .N_RST(2)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .cfg   (cfg_if),
        .clko  (clko),
        .clkob (clkob),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Period monitor: samples just after each rising edge.
    int mon_len  = 0;
    int mon_high = 0;
    bit in_period = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            in_period = 1'b0;
            mon_len   = 0;
            mon_high  = 0;
        end else begin
            check_eq("clkob_inv", int'(clkob), int'(!clko));
            if (!in_period) begin
                if (clko) begin
                    in_period = 1'b1;
                    mon_len   = 1;
                    mon_high  = 1;
                end
            end else begin
                mon_len++;
                if (clko) mon_high++;
            end
            if (tick) begin
                check_eq("tick_in_period", int'(in_period), 1);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_period_len", mon_len, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check_eq("period_len", mon_len, e);
                    check_eq("period_high", mon_high, e / 2);
                end
                in_period = 1'b0;
                mon_len   = 0;
                mon_high  = 0;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        check_eq("tick_count_in_budget", seen, n);
    endtask

    // Offer one config at the current negedge; it is accepted on the next edge.
    task automatic send_cfg(input int n, input int frac, input bit fen);
        check_eq("cfg_ready_free", int'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = W'(n);
        cfg_if.cfg_frac  = F'(frac);
        cfg_if.cfg_fen   = fen;
        @(negedge clk);
        check_eq("cfg_ready_busy", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic push_n(input int len, input int times);
        for (int i = 0; i < times; i++) exp_q.push_back(len);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int tcount;
        rstn = 1'b1;
        en   = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_n     = '0;
        cfg_if.cfg_frac  = '0;
        cfg_if.cfg_fen   = 1'b0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_clko", int'(clko), 0);
        check_eq("rst_clkob", int'(clkob), 1);
        check_eq("rst_tick", int'(tick), 0);
        check_eq("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_clko", int'(clko), 0);

        // Divide by reset ratio 2.
        push_n(2, 4);
        en = 1'b1;
        wait_ticks(4);

        // Integer ratio walk; each change is offered on a tick cycle.
        push_n(2, 1); push_n(3, 3);
        send_cfg(3, 0, 1'b0);
        wait_ticks(4);
        push_n(3, 1); push_n(5, 3);
        send_cfg(5, 0, 1'b0);
        wait_ticks(4);
        push_n(5, 1); push_n(13, 2);
        send_cfg(13, 0, 1'b0);
        wait_ticks(3);
        push_n(13, 1); push_n(23, 2);
        send_cfg(23, 0, 1'b0);
        wait_ticks(3);

        // Fractional 4 + 0x40/256: periods 4,4,4,5 repeating.
        push_n(23, 1);
        for (int k = 0; k < 3; k++) begin
            push_n(4, 3); push_n(5, 1);
        end
        send_cfg(4, 8'h40, 1'b1);
        wait_ticks(9);
        tcount = 0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (tick) tcount++;
        end
        check_eq("ticks_in_17", tcount, 4);

        // cfg_n=0 clamps to 2; a second offer while pending is dropped.
        push_n(4, 1); push_n(2, 3);
        send_cfg(0, 0, 1'b0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = W'(7);
        @(negedge clk);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        wait_ticks(1);
        check_eq("ready_low_before_apply", int'(cfg_if.cfg_ready), 0);
        @(negedge clk);
        check_eq("ready_high_after_apply", int'(cfg_if.cfg_ready), 1);
        wait_ticks(3);

        // cfg_n=1 clamps to 2.
        push_n(2, 4);
        send_cfg(1, 0, 1'b0);
        wait_ticks(4);

        // en dropped mid-period: the 9-cycle period still completes.
        push_n(2, 1); push_n(9, 1);
        send_cfg(9, 0, 1'b0);
        wait_ticks(1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_ticks(1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("idle_after_en_clko", int'(clko), 0);
            check_eq("idle_after_en_tick", int'(tick), 0);
        end

        // Asynchronous reset mid-period with a config pending.
        push_n(9, 1);
        en = 1'b1;
        repeat (3) @(negedge clk);
        send_cfg(5, 0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_clko", int'(clko), 0);
        check_eq("arst_clkob", int'(clkob), 1);
        check_eq("arst_tick", int'(tick), 0);
        check_eq("arst_cfg_ready", int'(cfg_if.cfg_ready), 1);
        exp_q.delete();
        en = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_clko", int'(clko), 0);

        // Reset ratio is back to 2, pending 5 was discarded.
        push_n(2, 2);
        en = 1'b1;
        wait_ticks(2);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("final_idle_clko", int'(clko), 0);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
